// File: rtl/risc4_pkg.sv
// Shared types for the 4-bit execute stage: opcodes, multiplier FSM states, widths.
package risc4_pkg;
    localparam int DW = 4;  // datapath width
    localparam int AW = 4;  // register index width

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_ADC  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_LDI  = 4'h7,
        OP_MOV  = 4'h8,
        OP_SHL  = 4'h9,
        OP_SHR  = 4'hA,
        OP_MUL  = 4'hB,
        OP_MFHI = 4'hC
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;
endpackage

// File: rtl/alu_exec_if.sv
// Decode-to-execute request bundle plus register-file write port and status.
interface alu_exec_if;
    import risc4_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs_a;
    logic [AW-1:0] in_rs_b;
    logic [DW-1:0] in_data_a;
    logic [DW-1:0] in_data_b;
    logic [DW-1:0] in_imm;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          flag_c;
    logic          flag_z;
    logic          illegal;
    logic          busy;

    modport master (
        output in_valid, in_op, in_rd, in_rs_a, in_rs_b, in_data_a, in_data_b, in_imm,
        input  in_ready, wb_en, wb_addr, wb_data, flag_c, flag_z, illegal, busy
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs_a, in_rs_b, in_data_a, in_data_b, in_imm,
        output in_ready, wb_en, wb_addr, wb_data, flag_c, flag_z, illegal, busy
    );
endinterface

// File: rtl/mul4_seq.sv
// Sequential shift-add multiplier: one multiplier bit per edge after start, DW steps.
module mul4_seq
    import risc4_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            done,
    output logic [2*DW-1:0] product
);
    localparam int CW = $clog2(DW);

    logic [2*DW-1:0] mcand;
    logic [2*DW-1:0] acc;
    logic [DW-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic            run;
    logic [2*DW-1:0] addend;

    // product includes the step in flight, so it is final while done is high
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = run && (cnt == CW'(DW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= {{DW{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_exec.sv
// 4-bit execute stage with write-back bypass. Define RISC4_MUL_EN to build the
// multi-cycle MUL/MFHI path (HI register, IDLE/MUL/FIN sequencer, mul4_seq).
module alu_exec
    import risc4_pkg::*;
#(
    parameter int FORWARD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);
    logic          wb_en_q;
    logic [AW-1:0] wb_addr_q;
    logic [DW-1:0] wb_data_q;
    logic          flag_c_q;
    logic          flag_z_q;
    logic          illegal_q;
    logic          busy;
    logic          accept;
    logic          fwd_a;
    logic          fwd_b;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    op_e           op;

    logic [DW:0]   sum;
    logic [DW-1:0] res;
    logic          c_new;
    logic          c_upd;
    logic          writes;
    logic          reserved;

`ifdef RISC4_MUL_EN
    state_e          state;
    logic [1:0]      step;
    logic [DW-1:0]   hi;
    logic [AW-1:0]   mul_rd;
    logic            is_mul;
    logic            mul_done;
    logic            mul_wr;
    logic [2*DW-1:0] product;

    assign busy   = (state != ST_IDLE);
    assign mul_wr = (state == ST_FIN) && mul_done;
`else
    assign busy = 1'b0;
`endif

    assign bus.in_ready = ~busy;
    assign accept       = bus.in_valid & ~busy;
    assign op           = op_e'(bus.in_op);

    // Bypass the registered write-back result; r0 is never forwarded.
    assign fwd_a = (FORWARD != 0) && wb_en_q && (wb_addr_q == bus.in_rs_a) && (wb_addr_q != '0);
    assign fwd_b = (FORWARD != 0) && wb_en_q && (wb_addr_q == bus.in_rs_b) && (wb_addr_q != '0);
    assign opa   = fwd_a ? wb_data_q : bus.in_data_a;
    assign opb   = fwd_b ? wb_data_q : bus.in_data_b;

    always_comb begin
        sum      = '0;
        res      = '0;
        c_new    = 1'b0;
        c_upd    = 1'b0;
        writes   = 1'b1;
        reserved = 1'b0;
`ifdef RISC4_MUL_EN
        is_mul   = 1'b0;
`endif
        case (op)
            OP_NOP: writes = 1'b0;
            OP_ADD: begin
                sum   = {1'b0, opa} + {1'b0, opb};
                res   = sum[DW-1:0];
                c_new = sum[DW];
                c_upd = 1'b1;
            end
            OP_ADC: begin
                sum   = {1'b0, opa} + {1'b0, opb} + {{DW{1'b0}}, flag_c_q};
                res   = sum[DW-1:0];
                c_new = sum[DW];
                c_upd = 1'b1;
            end
            OP_SUB: begin
                sum   = {1'b0, opa} + {1'b0, ~opb} + {{DW{1'b0}}, 1'b1};
                res   = sum[DW-1:0];
                c_new = sum[DW];
                c_upd = 1'b1;
            end
            OP_AND: res = opa & opb;
            OP_OR:  res = opa | opb;
            OP_XOR: res = opa ^ opb;
            OP_LDI: res = bus.in_imm;
            OP_MOV: res = opa;
            OP_SHL: begin
                res   = {opa[DW-2:0], 1'b0};
                c_new = opa[DW-1];
                c_upd = 1'b1;
            end
            OP_SHR: begin
                res   = {1'b0, opa[DW-1:1]};
                c_new = opa[0];
                c_upd = 1'b1;
            end
`ifdef RISC4_MUL_EN
            OP_MUL: begin
                writes = 1'b0;
                is_mul = 1'b1;
            end
            OP_MFHI: res = hi;
`endif
            default: begin
                writes   = 1'b0;
                reserved = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            wb_en_q   <= 1'b0;
            illegal_q <= accept & reserved;
            if (accept && writes) begin
                flag_z_q <= (res == '0);
                if (c_upd) flag_c_q <= c_new;
                if (bus.in_rd != '0) begin
                    wb_en_q   <= 1'b1;
                    wb_addr_q <= bus.in_rd;
                    wb_data_q <= res;
                end
            end
`ifdef RISC4_MUL_EN
            if (mul_wr) begin
                flag_z_q <= (product[DW-1:0] == '0);
                flag_c_q <= (product[2*DW-1:DW] != '0);
                if (mul_rd != '0) begin
                    wb_en_q   <= 1'b1;
                    wb_addr_q <= mul_rd;
                    wb_data_q <= product[DW-1:0];
                end
            end
`endif
        end
    end

`ifdef RISC4_MUL_EN
    mul4_seq u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept & is_mul),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (product)
    );

    // MUL covers the first DW-1 shift-add steps; FIN takes the last one and retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            step   <= '0;
            hi     <= '0;
            mul_rd <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept && is_mul) begin
                    state  <= ST_MUL;
                    step   <= '0;
                    mul_rd <= bus.in_rd;
                end
                ST_MUL: begin
                    step <= step + 1'b1;
                    if (step == 2'(DW - 2)) state <= ST_FIN;
                end
                ST_FIN: begin
                    if (mul_done) hi <= product[2*DW-1:DW];
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

    assign bus.wb_en   = wb_en_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;
    assign bus.flag_c  = flag_c_q;
    assign bus.flag_z  = flag_z_q;
    assign bus.illegal = illegal_q;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vectors, an arithmetic reference model checked every cycle,
// and literal expectations at key points. Covers the MUL path when RISC4_MUL_EN is defined.
module tb_alu_exec;
    import risc4_pkg::*;

`ifdef RISC4_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_exec_if bus ();

    alu_exec #(.FORWARD(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errs    = 0;
    int checks  = 0;
    bit started = 1'b0;

    // reference model state
    bit m_en   = 1'b0;
    int m_addr = 0, m_data = 0, m_c = 0, m_z = 0, m_ill = 0;
    int m_busy = 0, m_hi = 0, m_pa = 0, m_pb = 0, m_prd = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int a, b, r, s;
        bit wr;
        if (!rst_n) begin
            m_en = 0; m_addr = 0; m_data = 0; m_c = 0; m_z = 0; m_ill = 0;
            m_busy = 0; m_hi = 0;
            return;
        end
        m_ill = 0;
        if (m_busy > 0) begin
            m_busy--;
            m_en = 0;
            if (m_busy == 0) begin
                s    = m_pa * m_pb;
                m_hi = s / 16;
                r    = s % 16;
                m_c  = (m_hi != 0);
                m_z  = (r == 0);
                if (m_prd != 0) begin
                    m_en = 1; m_addr = m_prd; m_data = r;
                end
            end
        end else if (bus.in_valid) begin
            a  = (m_en && m_addr == int'(bus.in_rs_a) && m_addr != 0) ? m_data : int'(bus.in_data_a);
            b  = (m_en && m_addr == int'(bus.in_rs_b) && m_addr != 0) ? m_data : int'(bus.in_data_b);
            wr = 1;
            r  = 0;
            case (int'(bus.in_op))
                1:  begin s = a + b;       r = s % 16; m_c = (s > 15); end
                2:  begin s = a + b + m_c; r = s % 16; m_c = (s > 15); end
                3:  begin r = (a - b + 16) % 16; m_c = (a >= b); end
                4:  r = a & b;
                5:  r = a | b;
                6:  r = a ^ b;
                7:  r = int'(bus.in_imm);
                8:  r = a;
                9:  begin r = (a * 2) % 16; m_c = (a >= 8); end
                10: begin r = a / 2; m_c = a % 2; end
                11: begin
                    wr = 0;
                    if (MUL_EN) begin m_busy = 4; m_pa = a; m_pb = b; m_prd = int'(bus.in_rd); end
                    else m_ill = 1;
                end
                12: begin
                    if (MUL_EN) r = m_hi;
                    else begin wr = 0; m_ill = 1; end
                end
                0:  wr = 0;
                default: begin wr = 0; m_ill = 1; end
            endcase
            m_en = 0;
            if (wr) begin
                m_z = (r == 0);
                if (bus.in_rd != 0) begin
                    m_en = 1; m_addr = int'(bus.in_rd); m_data = r;
                end
            end
        end else begin
            m_en = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("wb_en", {7'b0, bus.wb_en}, {7'b0, m_en});
            if (m_en) begin
                check("wb_addr", {4'b0, bus.wb_addr}, 8'(m_addr));
                check("wb_data", {4'b0, bus.wb_data}, 8'(m_data));
            end
            check("flag_c", {7'b0, bus.flag_c}, 8'(m_c));
            check("flag_z", {7'b0, bus.flag_z}, 8'(m_z));
            check("illegal", {7'b0, bus.illegal}, 8'(m_ill));
            check("busy", {7'b0, bus.busy}, 8'(m_busy != 0));
            check("in_ready", {7'b0, bus.in_ready}, 8'(m_busy == 0));
        end
    end

    // present one request for a single edge, starting from a negedge
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] da, input logic [3:0] db,
                         input logic [3:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_rd     = rd;
        bus.in_rs_a   = ra;
        bus.in_rs_b   = rb;
        bus.in_data_a = da;
        bus.in_data_b = db;
        bus.in_imm    = imm;
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    task automatic lit_wb(input string name, input logic [3:0] addr, input logic [3:0] data);
        check({name, ".en"}, {7'b0, bus.wb_en}, 8'd1);
        check({name, ".addr"}, {4'b0, bus.wb_addr}, {4'b0, addr});
        check({name, ".data"}, {4'b0, bus.wb_data}, {4'b0, data});
    endtask

    task automatic lit_flags(input string name, input logic c, input logic z);
        check({name, ".c"}, {7'b0, bus.flag_c}, {7'b0, c});
        check({name, ".z"}, {7'b0, bus.flag_z}, {7'b0, z});
    endtask

    task automatic lit_reset(input string name);
        check({name, ".wb_en"}, {7'b0, bus.wb_en}, 8'd0);
        check({name, ".wb_addr"}, {4'b0, bus.wb_addr}, 8'd0);
        check({name, ".wb_data"}, {4'b0, bus.wb_data}, 8'd0);
        lit_flags(name, 1'b0, 1'b0);
        check({name, ".illegal"}, {7'b0, bus.illegal}, 8'd0);
        check({name, ".busy"}, {7'b0, bus.busy}, 8'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs_a = '0;
        bus.in_rs_b = '0; bus.in_data_a = '0; bus.in_data_b = '0; bus.in_imm = '0;
        repeat (2) @(negedge clk);
        lit_reset("reset");
        check("reset.in_ready", {7'b0, bus.in_ready}, 8'd1);
        rst_n   = 1'b1;
        started = 1'b1;
        @(negedge clk);

        // forwarded back-to-back: 9 + 9 = 0x12 -> 2, carry out
        issue(OP_LDI, 4'd3, 4'd0, 4'd0, 4'h0, 4'h0, 4'h9);
        lit_wb("ldi", 4'd3, 4'h9);
        issue(OP_ADD, 4'd4, 4'd3, 4'd3, 4'h0, 4'h0, 4'h0);
        lit_wb("add_fwd", 4'd4, 4'h2);
        lit_flags("add_fwd", 1'b1, 1'b0);

        issue(OP_SUB, 4'd1, 4'd7, 4'd8, 4'h5, 4'h5, 4'h0);
        lit_wb("sub_eq", 4'd1, 4'h0);
        lit_flags("sub_eq", 1'b1, 1'b1);
        issue(OP_SUB, 4'd1, 4'd7, 4'd8, 4'h2, 4'h3, 4'h0);
        lit_wb("sub_borrow", 4'd1, 4'hF);
        lit_flags("sub_borrow", 1'b0, 1'b0);

        // rd==0 suppresses write-back but still sets flags
        issue(OP_ADD, 4'd0, 4'd7, 4'd8, 4'h8, 4'h8, 4'h0);
        check("add_r0.wb_en", {7'b0, bus.wb_en}, 8'd0);
        lit_flags("add_r0", 1'b1, 1'b1);
        issue(4'hD, 4'd2, 4'd7, 4'd8, 4'h1, 4'h1, 4'h0);
        check("rsvd.illegal", {7'b0, bus.illegal}, 8'd1);
        check("rsvd.wb_en", {7'b0, bus.wb_en}, 8'd0);
        lit_flags("rsvd", 1'b1, 1'b1);
        @(negedge clk);
        check("rsvd.pulse_end", {7'b0, bus.illegal}, 8'd0);

        issue(OP_ADC, 4'd2, 4'd7, 4'd8, 4'h1, 4'h1, 4'h0);
        lit_wb("adc", 4'd2, 4'h3);
        lit_flags("adc", 1'b0, 1'b0);
        issue(OP_ADC, 4'd2, 4'd7, 4'd8, 4'h9, 4'h7, 4'h0);

        // rs_b bypass: 3 ^ 6 = 5
        issue(OP_MOV, 4'd5, 4'd9, 4'd9, 4'h6, 4'h0, 4'h0);
        issue(OP_XOR, 4'd6, 4'd1, 4'd5, 4'h3, 4'h0, 4'h0);
        lit_wb("xor_fwd_b", 4'd6, 4'h5);
        issue(OP_SHL, 4'd7, 4'd9, 4'd9, 4'h9, 4'h0, 4'h0);
        lit_wb("shl", 4'd7, 4'h2);
        check("shl.c", {7'b0, bus.flag_c}, 8'd1);
        issue(OP_SHR, 4'd7, 4'd2, 4'd2, 4'h8, 4'h0, 4'h0);
        lit_wb("shr", 4'd7, 4'h4);
        check("shr.c", {7'b0, bus.flag_c}, 8'd0);
        issue(OP_SHR, 4'd8, 4'd2, 4'd2, 4'h9, 4'h0, 4'h0);
        issue(OP_AND, 4'd9, 4'd1, 4'd2, 4'hC, 4'hA, 4'h0);
        issue(OP_OR,  4'd9, 4'd1, 4'd2, 4'h4, 4'h2, 4'h0);
        issue(OP_AND, 4'd9, 4'd9, 4'd2, 4'h0, 4'h1, 4'h0);
        issue(OP_NOP, 4'd3, 4'd1, 4'd2, 4'h0, 4'h0, 4'h0);
        issue(4'hE, 4'd3, 4'd1, 4'd2, 4'h0, 4'h0, 4'h0);
        issue(4'hF, 4'd3, 4'd1, 4'd2, 4'h0, 4'h0, 4'h0);
        bus.in_op = OP_ADD; bus.in_rd = 4'd3;  // ignored: in_valid low
        @(negedge clk);

`ifdef RISC4_MUL_EN
        issue(OP_MUL, 4'd2, 4'd10, 4'd11, 4'hF, 4'hF, 4'h0);
        for (int i = 0; i < 4; i++) begin
            check("mul.busy", {7'b0, bus.busy}, 8'd1);
            check("mul.in_ready", {7'b0, bus.in_ready}, 8'd0);
            bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_rd = 4'd9;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        lit_wb("mul", 4'd2, 4'h1);
        check("mul.done_busy", {7'b0, bus.busy}, 8'd0);
        lit_flags("mul", 1'b1, 1'b0);
        issue(OP_MFHI, 4'd5, 4'd10, 4'd11, 4'h0, 4'h0, 4'h0);
        lit_wb("mfhi", 4'd5, 4'hE);
        check("mfhi.c", {7'b0, bus.flag_c}, 8'd1);
        issue(OP_MUL, 4'd2, 4'd10, 4'd11, 4'h3, 4'h3, 4'h0);
        @(negedge clk);
`else
        issue(OP_MUL, 4'd2, 4'd10, 4'd11, 4'hF, 4'hF, 4'h0);
        check("mul_off.illegal", {7'b0, bus.illegal}, 8'd1);
        check("mul_off.in_ready", {7'b0, bus.in_ready}, 8'd1);
        check("mul_off.wb_en", {7'b0, bus.wb_en}, 8'd0);
        issue(OP_MFHI, 4'd5, 4'd10, 4'd11, 4'h0, 4'h0, 4'h0);
        check("mfhi_off.illegal", {7'b0, bus.illegal}, 8'd1);
        issue(OP_LDI, 4'd2, 4'd0, 4'd0, 4'h0, 4'h0, 4'h7);
`endif

        // asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        lit_reset("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lit_reset("post_rst");
        check("post_rst.in_ready", {7'b0, bus.in_ready}, 8'd1);
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter FORWARD, default 1, enables operand bypass from the write-back register.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid / in_ready  in/out  1/1  decode-to-execute handshake; transfer on edge with both high.
REQ-005 in_op  in  4  opcode: 0 NOP, 1 ADD, 2 ADC, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 LDI, 8 MOV, 9 SHL, A SHR, B MUL, C MFHI, D-F reserved.
REQ-006 in_rd, in_rs_a, in_rs_b  in  4 each  destination and source register indices.
REQ-007 in_data_a, in_data_b, in_imm  in  4 each  register-file read data A/B and immediate.
REQ-008 wb_en, wb_addr, wb_data  out  1/4/4  register-file write port.
REQ-009 flag_c, flag_z  out  1 each  carry and zero flags.
REQ-010 illegal  out  1  one-cycle pulse for a reserved opcode.
REQ-011 busy  out  1  high while a multi-cycle op is in progress.

Function
REQ-012 Single-cycle ops accepted at edge N SHALL present wb_en/wb_addr/wb_data after edge N and drop wb_en after edge N+1 unless another op completes.
REQ-013 wb_en SHALL stay low when in_rd==0 and for NOP, reserved opcodes and MUL acceptance.
REQ-014 Results, all 4-bit, truncated: ADD a+b; ADC a+b+C; SUB a+~b+1; AND/OR/XOR bitwise; LDI imm; MOV a; SHL a<<1; SHR a>>1; MFHI HI.
REQ-015 flag_c SHALL be updated by ADD/ADC/SUB (carry out, 1=no borrow), SHL (old bit3), SHR (old bit0), and MUL (HI!=0); all other ops SHALL hold it.
REQ-016 flag_z SHALL be set to (result==0) on every op that writes back or would write back with rd==0; NOP/reserved ops SHALL hold it.
REQ-017 With FORWARD=1, while wb_en is high and wb_addr==in_rs_a (or in_rs_b) and wb_addr!=0, the corresponding operand SHALL be wb_data instead of in_data_a/b.
REQ-018 in_ready SHALL equal !busy; in_data is ignored when in_valid is low.
REQ-019 FSM states IDLE, MUL, FIN: IDLE->MUL on MUL accept; MUL iterates one shift-add bit per edge, 4 edges; FIN registers result and returns to IDLE.
REQ-020 MUL accepted at edge N SHALL assert busy from after edge N, write low nibble to rd and high nibble to HI at edge N+4, with busy low and wb_en high after edge N+4.
REQ-021 Reserved opcode SHALL pulse illegal one cycle after acceptance, with no write-back and no flag change.
REQ-022 HI register SHALL be written only by MUL completion.

Reset
REQ-023 On rst_n low, immediately: wb_en=0, wb_addr=0, wb_data=0, flag_c=0, flag_z=0, illegal=0, busy=0, HI=0, FSM=IDLE.
REQ-024 A multiply in progress at reset SHALL be abandoned with no write-back; in_ready is high on the first cycle after release.

Configuration
REQ-025 Macro RISC4_MUL_EN: when defined, MUL/MFHI, HI and the MUL/FIN states are built.
REQ-026 When RISC4_MUL_EN is undefined, opcodes B and C SHALL be treated as reserved, busy SHALL tie to 0, and in_ready SHALL tie to 1.

Structure
REQ-027 Package risc4_pkg SHALL hold the opcode enum, the FSM state enum, and the data width constant (4).
REQ-028 The sequential shift-add multiplier SHALL be the sub-module mul4_seq (start, a, b -> done, product[7:0]), instantiated only under RISC4_MUL_EN.

Verification
REQ-029 LDI rd=3 imm=9, then ADD rd=4 rs_a=3 rs_b=3 back-to-back -> forwarded: wb 3<-9, then wb 4<-2, flag_c=1, flag_z=0.
REQ-030 SUB a=5 b=5 rd=1 -> wb_data=0, flag_z=1, flag_c=1; SUB a=2 b=3 -> wb_data=F, flag_c=0.
REQ-031 MUL a=F b=F rd=2 -> busy for 4 cycles, in_ready low, wb 2<-1, then MFHI rd=5 -> wb 5<-E, flag_c=1.
REQ-032 ADD rd=0 a=8 b=8 -> wb_en stays 0, flag_c=1, flag_z=1; op D -> illegal pulses once, flags unchanged.
REQ-033 rst_n low 2 cycles after MUL accept -> no write-back, busy=0 and all outputs 0 after release.
REQ-034 Build without RISC4_MUL_EN, issue op B -> illegal pulse, in_ready constantly 1.
